// File: rtl/aclint_pkg.sv
// Shared definitions for the BRAM-mapped ACLINT: register offsets, reset values, byte-lane merge.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package aclint_pkg;

  // Byte offsets of each register window within the 64 KiB aperture.
  localparam logic [15:0] MSIP_BASE     = 16'h0000;
  localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
  localparam logic [15:0] MTIME_LO      = 16'hBFF8;
  localparam logic [15:0] MTIME_HI      = 16'hBFFC;
  localparam logic [15:0] SSIP_BASE     = 16'hC000;

  // mtimecmp resets to the largest value so no timer interrupt fires until software programs it.
  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  // Replace only the byte lanes selected by we; other lanes keep old_val.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] wr_val,
                                             input logic [3:0]  we);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = we[b] ? wr_val[8*b +: 8] : old_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/aclint_prescaler.sv
// Fractional prescaler: emits TIMER_FREQ single-cycle ticks per CLK_FREQ clk cycles, drift-free.
// Latency: tick is combinational from the accumulator flop; first tick ceil(CLK_FREQ/TIMER_FREQ) cycles after reset.
// Backpressure: none; free-running.
// Ports: clk, rstn (async active-low), tick (1-cycle strobe).
module aclint_prescaler #(
  parameter int CLK_FREQ   = 40,
  parameter int TIMER_FREQ = 10
) (
  input  logic clk,
  input  logic rstn,
  output logic tick
);

  localparam int AW = $clog2(2 * CLK_FREQ);

  logic [AW-1:0] acc_q, acc_d;
  // One extra bit so acc + TIMER_FREQ never wraps before the compare.
  logic [AW:0]   sum;

  always_comb begin
    sum   = {1'b0, acc_q} + (AW+1)'(TIMER_FREQ);
    tick  = (sum >= (AW+1)'(CLK_FREQ));
    acc_d = tick ? AW'(sum - (AW+1)'(CLK_FREQ)) : AW'(sum);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/aclint_bram.sv
// ACLINT (msip/ssip/mtimecmp/mtime) behind a 32-bit, read-latency-1 BRAM-controller port.
// Latency: reads return one cycle after bram_en; writes land at the edge ending the access; mtip one edge after its inputs.
// Backpressure: none; every access is accepted every cycle.
// Ports: clk, rstn (async active-low); bram_addr/en/we/wrdata in, bram_rddata out;
//        msip, ssip, mtip out, one bit per hart.
module aclint_bram
  import aclint_pkg::*;
#(
  parameter int NUM_HARTS  = 1,
  parameter int CLK_FREQ   = 40,
  parameter int TIMER_FREQ = 10
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [15:0]          bram_addr,
  input  logic                 bram_en,
  input  logic [3:0]           bram_we,
  output logic [31:0]          bram_rddata,
  input  logic [31:0]          bram_wrdata,
  output logic [NUM_HARTS-1:0] msip,
  output logic [NUM_HARTS-1:0] ssip,
  output logic [NUM_HARTS-1:0] mtip
);

  logic tick;

  aclint_prescaler #(
    .CLK_FREQ   (CLK_FREQ),
    .TIMER_FREQ (TIMER_FREQ)
  ) u_prescaler (
    .clk  (clk),
    .rstn (rstn),
    .tick (tick)
  );

  // ---------------- address decode ----------------
  logic       wr;
  logic [9:0] idx4;   // hart index for 4-byte-stride windows
  logic [9:0] idx8;   // hart index for 8-byte-stride mtimecmp window
  logic       sel_msip, sel_ssip, sel_cmp, sel_mlo, sel_mhi;
  logic [1:0] unused_addr_lsb;

  assign unused_addr_lsb = bram_addr[1:0];
  assign wr       = bram_en && (bram_we != 4'b0000);
  assign idx4     = bram_addr[11:2];
  assign idx8     = bram_addr[12:3];
  // Windows are sized for 1024 harts; indices beyond NUM_HARTS simply match no register.
  assign sel_msip = (bram_addr[15:12] == MSIP_BASE[15:12]);
  assign sel_ssip = (bram_addr[15:12] == SSIP_BASE[15:12]);
  assign sel_cmp  = (bram_addr[15:13] == MTIMECMP_BASE[15:13]);
  assign sel_mlo  = (bram_addr[15:2]  == MTIME_LO[15:2]);
  assign sel_mhi  = (bram_addr[15:2]  == MTIME_HI[15:2]);

  // ---------------- state ----------------
  logic [NUM_HARTS-1:0] msip_q, msip_d;
  logic [NUM_HARTS-1:0] ssip_q, ssip_d;
  logic [NUM_HARTS-1:0] mtip_q, mtip_d;
  logic [63:0]          mtimecmp_q [NUM_HARTS];
  logic [63:0]          mtimecmp_d [NUM_HARTS];
  logic [63:0]          mtime_q, mtime_d;
  logic [31:0]          rddata_q, rddata_d;
  logic [31:0]          rd_word;

  // Per-hart register writes and timer compares.
  always_comb begin
    msip_d = msip_q;
    ssip_d = ssip_q;
    mtip_d = mtip_q;
    for (int h = 0; h < NUM_HARTS; h++) begin
      mtimecmp_d[h] = mtimecmp_q[h];
      // Compare uses current register values; the result lands one edge later.
      mtip_d[h] = (mtime_q >= mtimecmp_q[h]);
      if (wr && (idx4 == 10'(h)) && bram_we[0]) begin
        if (sel_msip) msip_d[h] = bram_wrdata[0];
        if (sel_ssip) ssip_d[h] = bram_wrdata[0];
      end
      if (wr && sel_cmp && (idx8 == 10'(h))) begin
        if (bram_addr[2]) begin
          mtimecmp_d[h][63:32] = byte_merge(mtimecmp_q[h][63:32], bram_wrdata, bram_we);
        end else begin
          mtimecmp_d[h][31:0]  = byte_merge(mtimecmp_q[h][31:0], bram_wrdata, bram_we);
        end
      end
    end
  end

  // mtime: a software write to either half wins over the tick increment in that cycle,
  // and leaves the other half untouched (no carry into it).
  always_comb begin
    mtime_d = tick ? (mtime_q + 64'd1) : mtime_q;
    if (wr && sel_mlo) begin
      mtime_d = {mtime_q[63:32], byte_merge(mtime_q[31:0], bram_wrdata, bram_we)};
    end else if (wr && sel_mhi) begin
      mtime_d = {byte_merge(mtime_q[63:32], bram_wrdata, bram_we), mtime_q[31:0]};
    end
  end

  // Read mux samples pre-write values, giving read-first behaviour on a same-word write.
  always_comb begin
    rd_word = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (sel_msip && (idx4 == 10'(h))) rd_word = {31'd0, msip_q[h]};
      if (sel_ssip && (idx4 == 10'(h))) rd_word = {31'd0, ssip_q[h]};
      if (sel_cmp && (idx8 == 10'(h))) begin
        rd_word = bram_addr[2] ? mtimecmp_q[h][63:32] : mtimecmp_q[h][31:0];
      end
    end
    if (sel_mlo) rd_word = mtime_q[31:0];
    if (sel_mhi) rd_word = mtime_q[63:32];
    rddata_d = bram_en ? rd_word : rddata_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      msip_q   <= '0;
      ssip_q   <= '0;
      mtip_q   <= '0;
      mtime_q  <= '0;
      rddata_q <= '0;
      for (int h = 0; h < NUM_HARTS; h++) begin
        mtimecmp_q[h] <= MTIMECMP_RST;
      end
    end else begin
      msip_q   <= msip_d;
      ssip_q   <= ssip_d;
      mtip_q   <= mtip_d;
      mtime_q  <= mtime_d;
      rddata_q <= rddata_d;
      for (int h = 0; h < NUM_HARTS; h++) begin
        mtimecmp_q[h] <= mtimecmp_d[h];
      end
    end
  end

  assign bram_rddata = rddata_q;
  assign msip        = msip_q;
  assign ssip        = ssip_q;
  assign mtip        = mtip_q;

endmodule

// File: tb/tb_aclint_bram.sv
// Self-checking bench for aclint_bram with 3 harts, 40 MHz clock, 16 MHz timer.
// Latency: n/a.
// Backpressure: n/a.
module tb_aclint_bram;

  localparam int NH = 3;
  localparam int CF = 40;
  localparam int TF = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic [15:0]   bram_addr = '0;
  logic          bram_en = 1'b0;
  logic [3:0]    bram_we = '0;
  logic [31:0]   bram_wrdata = '0;
  logic [31:0]   bram_rddata;
  logic [NH-1:0] msip, ssip, mtip;

  aclint_bram #(
    .NUM_HARTS  (NH),
    .CLK_FREQ   (CF),
    .TIMER_FREQ (TF)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .bram_addr   (bram_addr),
    .bram_en     (bram_en),
    .bram_we     (bram_we),
    .bram_rddata (bram_rddata),
    .bram_wrdata (bram_wrdata),
    .msip        (msip),
    .ssip        (ssip),
    .mtip        (mtip)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mtime advances whenever floor(n*TF/CF) steps, n = cycles completed since reset release.
  longint unsigned m_cyc;
  logic [63:0]     m_mtime;
  logic [63:0]     m_cmp [NH];
  logic [NH-1:0]   m_msip, m_ssip, m_mtip, m_mtip_nxt;
  logic [31:0]     m_rd;
  bit              m_tk, m_mtime_wr;
  int              wa;

  function automatic bit tick_in(input longint unsigned n);
    return ((n * TF) / CF) != (((n - 1) * TF) / CF);
  endfunction

  function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n, input logic [3:0] we);
    logic [31:0] m;
    m = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
    return (o & ~m) | (n & m);
  endfunction

  function automatic logic [31:0] m_read(input logic [15:0] a_in);
    int a;
    a = int'(a_in) & 'hFFFC;
    if (a < 'h1000) begin
      if (a / 4 < NH) return {31'd0, m_msip[a/4]};
    end else if (a >= 'h4000 && a < 'h6000) begin
      if ((a - 'h4000) / 8 < NH)
        return (a % 8 == 4) ? m_cmp[(a-'h4000)/8][63:32] : m_cmp[(a-'h4000)/8][31:0];
    end else if (a == 'hBFF8) begin
      return m_mtime[31:0];
    end else if (a == 'hBFFC) begin
      return m_mtime[63:32];
    end else if (a >= 'hC000 && a < 'hD000) begin
      if ((a - 'hC000) / 4 < NH) return {31'd0, m_ssip[(a-'hC000)/4]};
    end
    return 32'd0;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_cyc   = 0;
      m_mtime = 64'd0;
      m_msip  = '0;
      m_ssip  = '0;
      m_mtip  = '0;
      m_rd    = 32'd0;
      for (int h = 0; h < NH; h++) m_cmp[h] = 64'hFFFF_FFFF_FFFF_FFFF;
    end else begin
      m_cyc++;
      m_tk = tick_in(m_cyc);
      m_mtime_wr = 1'b0;
      for (int h = 0; h < NH; h++) m_mtip_nxt[h] = (m_mtime >= m_cmp[h]);
      if (bram_en) m_rd = m_read(bram_addr);
      wa = int'(bram_addr) & 'hFFFC;
      if (bram_en && bram_we != 4'b0000) begin
        if (wa < 'h1000) begin
          if (wa / 4 < NH && bram_we[0]) m_msip[wa/4] = bram_wrdata[0];
        end else if (wa >= 'hC000 && wa < 'hD000) begin
          if ((wa - 'hC000) / 4 < NH && bram_we[0]) m_ssip[(wa-'hC000)/4] = bram_wrdata[0];
        end else if (wa >= 'h4000 && wa < 'h6000) begin
          if ((wa - 'h4000) / 8 < NH) begin
            if (wa % 8 == 4)
              m_cmp[(wa-'h4000)/8][63:32] = mrg(m_cmp[(wa-'h4000)/8][63:32], bram_wrdata, bram_we);
            else
              m_cmp[(wa-'h4000)/8][31:0] = mrg(m_cmp[(wa-'h4000)/8][31:0], bram_wrdata, bram_we);
          end
        end else if (wa == 'hBFF8) begin
          m_mtime[31:0] = mrg(m_mtime[31:0], bram_wrdata, bram_we);
          m_mtime_wr = 1'b1;
        end else if (wa == 'hBFFC) begin
          m_mtime[63:32] = mrg(m_mtime[63:32], bram_wrdata, bram_we);
          m_mtime_wr = 1'b1;
        end
      end
      if (m_tk && !m_mtime_wr) m_mtime = m_mtime + 64'd1;
      m_mtip = m_mtip_nxt;
    end
  end

  // Cycle-by-cycle comparison of all outputs against the model.
  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_rddata", bram_rddata, m_rd);
      check("cyc_msip", msip, m_msip);
      check("cyc_ssip", ssip, m_ssip);
      check("cyc_mtip", mtip, m_mtip);
    end
  end

  // ---------------- stimulus (called at a falling edge) ----------------
  task automatic bus_idle();
    bram_en = 1'b0;
    bram_we = 4'b0000;
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] we);
    bram_addr = a; bram_wrdata = d; bram_we = we; bram_en = 1'b1;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic bus_rd(input logic [15:0] a, output logic [31:0] d);
    bram_addr = a; bram_we = 4'b0000; bram_en = 1'b1;
    @(negedge clk);
    bus_idle();
    d = bram_rddata;
  endtask

  logic [15:0] boot_a [11] = '{16'hBFF8, 16'h4000, 16'h0000, 16'hBFF8, 16'hBFF8, 16'hBFF8,
                               16'hBFF8, 16'hBFF8, 16'hBFF8, 16'hBFF8, 16'hBFF8};
  // Read in cycle N returns mtime after N-1 cycles: floor((N-1)*16/40).
  logic [31:0] boot_e [11] = '{32'h0, 32'hFFFF_FFFF, 32'h0, 32'd1, 32'd1, 32'd2,
                               32'd2, 32'd2, 32'd3, 32'd3, 32'd4};

  initial begin
    logic [31:0] d;
    int k;

    #3 rstn = 1'b0;
    #1 chk_en = 1'b1;
    repeat (3) @(negedge clk);

    // Release reset and start a back-to-back read stream in the very first cycle.
    rstn = 1'b1;
    for (int i = 0; i < 11; i++) begin
      bram_addr = boot_a[i]; bram_we = 4'b0000; bram_en = 1'b1;
      @(negedge clk);
      check($sformatf("boot_rd%0d", i), bram_rddata, boot_e[i]);
    end
    bus_idle();
    check("boot_mtip", mtip, 3'b000);

    // 500 cycles after release: exactly 200 ticks.
    while (m_cyc < 500) @(negedge clk);
    bus_rd(16'hBFF8, d); check("mtime_500_lo", d, 32'd200);
    bus_rd(16'hBFFC, d); check("mtime_500_hi", d, 32'd0);

    // mtimecmp[1] = 50 with mtime restarted from 0.
    bus_wr(16'hBFF8, 32'd0, 4'hF);
    bus_wr(16'h400C, 32'd0, 4'hF);
    bus_wr(16'h4008, 32'd50, 4'hF);
    k = 0;
    while (m_mtime != 64'd50 && k < 2000) begin @(negedge clk); k++; end
    check("mtip_pre50", mtip, 3'b000);
    @(negedge clk);
    check("mtip_at50", mtip, 3'b010);

    // Carry from low into high word.
    bus_wr(16'hBFFC, 32'd0, 4'hF);
    bus_wr(16'hBFF8, 32'hFFFF_FFFF, 4'hF);
    k = 0;
    while (m_mtime[32] != 1'b1 && k < 100) begin @(negedge clk); k++; end
    bus_rd(16'hBFFC, d); check("carry_hi", d, 32'd1);
    bus_rd(16'hBFF8, d); check("carry_lo", d, 32'd0);

    // Partial write to mtime low in a tick cycle: merge, no increment.
    bus_wr(16'hBFF8, 32'hAAAA_0000, 4'hF);
    k = 0;
    while (!tick_in(m_cyc + 1) && k < 10) begin @(negedge clk); k++; end
    bus_wr(16'hBFF8, 32'h0000_1234, 4'b0011);
    bus_rd(16'hBFF8, d); check("merge_tick_lo", d, 32'hAAAA_1234);
    bus_rd(16'hBFFC, d); check("merge_tick_hi", d, 32'd1);

    // Software interrupts and out-of-range harts.
    bus_wr(16'h0008, 32'd1, 4'b0001);
    bus_wr(16'hC004, 32'd1, 4'b0001);
    check("msip_h2", msip, 3'b100);
    check("ssip_h1", ssip, 3'b010);
    bus_wr(16'h000C, 32'd1, 4'hF);
    check("msip_h3_ign", msip, 3'b100);
    bus_rd(16'h000C, d); check("rd_msip_h3", d, 32'd0);
    bus_wr(16'h0000, 32'hFFFF_FFFF, 4'b1110);
    check("msip_lane0_only", msip, 3'b100);

    // Read-first on a same-word write.
    bram_addr = 16'h0000; bram_wrdata = 32'd1; bram_we = 4'b0001; bram_en = 1'b1;
    @(negedge clk);
    bus_idle();
    check("read_first_old", bram_rddata, 32'd0);
    check("read_first_msip", msip, 3'b101);
    bus_rd(16'h0000, d); check("rd_msip_h0", d, 32'd1);
    bus_rd(16'hC004, d); check("rd_ssip_h1", d, 32'd1);
    bus_rd(16'h4014, d); check("rd_cmp2_hi", d, 32'hFFFF_FFFF);
    bus_rd(16'h4018, d); check("rd_cmp3_lo", d, 32'd0);
    bus_rd(16'h2000, d); check("rd_unmapped", d, 32'd0);
    bus_rd(16'h4008, d); check("rd_cmp1_lo", d, 32'd50);
    check("rddata_hold", bram_rddata, 32'd50);

    // Asynchronous reset mid-cycle, then an access in the first cycle after release.
    #2 rstn = 1'b0;
    #1;
    check("arst_msip", msip, 3'b000);
    check("arst_ssip", ssip, 3'b000);
    check("arst_mtip", mtip, 3'b000);
    check("arst_rddata", bram_rddata, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    bram_addr = 16'h4008; bram_we = 4'b0000; bram_en = 1'b1;
    @(negedge clk);
    bus_idle();
    check("post_rst_cmp1", bram_rddata, 32'hFFFF_FFFF);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
